// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares one multiplexed memory bus between the CPU core (port C) and the
//   console/debug loader (port D). Each granted request runs a fixed
//   sequence: address phase (ALE), data phase (En), capture, acknowledge.
//   Out-of-range addresses skip the bus entirely and acknowledge with err.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   pause                 masks port C requests at arbitration
//   c_*/d_* req,we,addr,wdata   requester inputs (level request)
//   c_*/d_* ack,err,rdata       one-cycle completion outputs
//   busy                  high whenever a transaction is in flight
//   Bus_Out, Bus_In       multiplexed address/write data out, read data in
//   ALE, En, Rw           address latch enable, access enable, 1=read
module bus_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              c_req,
  input  logic              d_req,
  input  logic              c_we,
  input  logic              d_we,
  input  logic [DATA_W-1:0] c_addr,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] c_wdata,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              c_ack,
  output logic              d_ack,
  output logic              c_err,
  output logic              d_err,
  output logic [DATA_W-1:0] c_rdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              busy,
  output logic [DATA_W-1:0] Bus_Out,
  input  logic [DATA_W-1:0] Bus_In,
  output logic              ALE,
  output logic              En,
  output logic              Rw
);

  typedef enum logic [2:0] {IDLE, ADDR, XFER, CAPT, DONE} state_t;

  state_t              state, state_nxt;
  logic                last_d, last_d_nxt;   // 1 = port D was granted last
  logic                rc, rd, win_d, start;
  logic                sel_we;
  logic [DATA_W-1:0]   sel_addr, sel_wdata;

  // Transaction register, loaded only when a request is granted in IDLE
  logic                own_d;
  logic                txn_we;
  logic                txn_err;
  logic [DATA_W-1:0]   txn_addr;
  logic [DATA_W-1:0]   txn_wdata;
  logic [DATA_W-1:0]   cap;

  // Extra top bit keeps the compare correct when MEM_DEPTH == 2**DATA_W
  function automatic logic out_of_range(input logic [DATA_W-1:0] a);
    return {1'b0, a} >= (DATA_W+1)'(MEM_DEPTH);
  endfunction

  assign rc    = c_req & ~pause;
  assign rd    = d_req;
  assign start = rc | rd;
  // D wins when alone, or on a tie when C was served last
  assign win_d = rd & (~rc | ~last_d);

  assign sel_we    = win_d ? d_we    : c_we;
  assign sel_addr  = win_d ? d_addr  : c_addr;
  assign sel_wdata = win_d ? d_wdata : c_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last_d <= 1'b1;
    end else begin
      state  <= state_nxt;
      last_d <= last_d_nxt;
    end
  end

  // Datapath registers carry no reset: every output that reads them is
  // gated by the (reset) state.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      own_d     <= win_d;
      txn_we    <= sel_we;
      txn_addr  <= sel_addr;
      txn_wdata <= sel_wdata;
      txn_err   <= out_of_range(sel_addr);
      cap       <= '0;
    end else if (state == CAPT) begin
      cap <= txn_we ? '0 : Bus_In;
    end
  end

  always_comb begin
    state_nxt  = state;
    last_d_nxt = last_d;
    ALE        = 1'b0;
    En         = 1'b0;
    Rw         = 1'b1;
    Bus_Out    = '0;
    c_ack      = 1'b0;
    c_err      = 1'b0;
    c_rdata    = '0;
    d_ack      = 1'b0;
    d_err      = 1'b0;
    d_rdata    = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          last_d_nxt = win_d;
          state_nxt  = out_of_range(sel_addr) ? DONE : ADDR;
        end
      end
      ADDR: begin
        ALE       = 1'b1;
        Bus_Out   = txn_addr;
        state_nxt = XFER;
      end
      XFER: begin
        En        = 1'b1;
        Rw        = ~txn_we;
        Bus_Out   = txn_we ? txn_wdata : '0;
        state_nxt = CAPT;
      end
      CAPT: begin
        state_nxt = DONE;
      end
      DONE: begin
        if (own_d) begin
          d_ack   = 1'b1;
          d_err   = txn_err;
          d_rdata = cap;
        end else begin
          c_ack   = 1'b1;
          c_err   = txn_err;
          c_rdata = cap;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst, pause;
  logic       c_req, d_req, c_we, d_we;
  logic [7:0] c_addr, d_addr, c_wdata, d_wdata;
  logic       c_ack, d_ack, c_err, d_err;
  logic [7:0] c_rdata, d_rdata;
  logic       busy;
  logic [7:0] Bus_Out, Bus_In;
  logic       ALE, En, Rw;

  int vecs = 0;
  int errs = 0;

  bus_arbiter #(.DATA_W(8), .MEM_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .c_req(c_req), .d_req(d_req), .c_we(c_we), .d_we(d_we),
    .c_addr(c_addr), .d_addr(d_addr), .c_wdata(c_wdata), .d_wdata(d_wdata),
    .c_ack(c_ack), .d_ack(d_ack), .c_err(c_err), .d_err(d_err),
    .c_rdata(c_rdata), .d_rdata(d_rdata), .busy(busy),
    .Bus_Out(Bus_Out), .Bus_In(Bus_In), .ALE(ALE), .En(En), .Rw(Rw)
  );

  always #5 clk = ~clk;

  // Memory model: latches address at the end of an ALE cycle, writes or
  // returns read data at the end of an En cycle.
  logic [7:0] mem [64];
  logic [7:0] lat = 8'h00;
  bit         loaded = 1'b0;
  initial Bus_In = 8'h00;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 3 + 1);
      mem[19] <= 8'h63;
      mem[8]  <= 8'h22;
      loaded  <= 1'b1;
    end else begin
      if (ALE) lat <= Bus_Out;
      if (En && !Rw) mem[lat[5:0]] <= Bus_Out;
      if (En && Rw) Bus_In <= mem[lat[5:0]];
    end
  end

  typedef struct {
    logic       rst, pause, c_req, c_we;
    logic [7:0] c_addr, c_wdata;
    logic       d_req, d_we;
    logic [7:0] d_addr, d_wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  // {Bus_Out, ALE, En, Rw, busy, c_ack, c_err, c_rdata, d_ack, d_err, d_rdata}
  function automatic logic [31:0] ex(input logic [7:0] bus, input logic ale, en, rw, bz,
                                     input logic ca, ce, input logic [7:0] cr,
                                     input logic da, de, input logic [7:0] dr);
    return {bus, ale, en, rw, bz, ca, ce, cr, da, de, dr};
  endfunction

  function automatic logic [31:0] e_idle();
    return ex(8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 0, 0, 8'h00);
  endfunction
  function automatic logic [31:0] e_addr(input logic [7:0] a);
    return ex(a, 1, 0, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00);
  endfunction
  function automatic logic [31:0] e_xfer(input logic [7:0] d, input logic rw);
    return ex(d, 0, 1, rw, 1, 0, 0, 8'h00, 0, 0, 8'h00);
  endfunction
  function automatic logic [31:0] e_capt();
    return ex(8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0, 8'h00);
  endfunction
  function automatic logic [31:0] e_cdone(input logic er, input logic [7:0] rdv);
    return ex(8'h00, 0, 0, 1, 1, 1, er, rdv, 0, 0, 8'h00);
  endfunction
  function automatic logic [31:0] e_ddone(input logic er, input logic [7:0] rdv);
    return ex(8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 1, er, rdv);
  endfunction

  task automatic add(input logic r, p, cq, cw, input logic [7:0] ca, cd,
                     input logic dq, dw, input logic [7:0] da, dd, input logic [31:0] e);
    vec_t v;
    v.rst = r; v.pause = p; v.c_req = cq; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.d_req = dq; v.d_we = dw; v.d_addr = da; v.d_wdata = dd; v.exp = e;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] outs();
    return {Bus_Out, ALE, En, Rw, busy, c_ack, c_err, c_rdata, d_ack, d_err, d_rdata};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s #%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic clear_inputs();
    pause = 0; c_req = 0; d_req = 0; c_we = 0; d_we = 0;
    c_addr = 0; d_addr = 0; c_wdata = 0; d_wdata = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();

    // reset state
    add(1,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_idle());
    // port D write 0x2A -> 0x05
    add(0,0, 0,0,8'h00,8'h00, 1,1,8'h05,8'h2A, e_idle());
    add(0,0, 0,0,8'h00,8'h00, 1,1,8'h05,8'h2A, e_addr(8'h05));
    add(0,0, 0,0,8'h00,8'h00, 1,1,8'h05,8'h2A, e_xfer(8'h2A, 0));
    add(0,0, 0,0,8'h00,8'h00, 1,1,8'h05,8'h2A, e_capt());
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_ddone(0, 8'h00));
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_idle());
    // port C read 0x13; inputs disturbed mid-flight must not matter
    add(0,0, 1,0,8'h13,8'h00, 0,0,8'h00,8'h00, e_idle());
    add(0,0, 1,0,8'h13,8'h00, 0,0,8'h00,8'h00, e_addr(8'h13));
    add(0,1, 1,1,8'h40,8'hFF, 0,0,8'h00,8'h00, e_xfer(8'h00, 1));
    add(0,1, 1,1,8'h40,8'hFF, 0,0,8'h00,8'h00, e_capt());
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_cdone(0, 8'h63));
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_idle());
    // port D reads back 0x05
    add(0,0, 0,0,8'h00,8'h00, 1,0,8'h05,8'h00, e_idle());
    add(0,0, 0,0,8'h00,8'h00, 1,0,8'h05,8'h00, e_addr(8'h05));
    add(0,0, 0,0,8'h00,8'h00, 1,0,8'h05,8'h00, e_xfer(8'h00, 1));
    add(0,0, 0,0,8'h00,8'h00, 1,0,8'h05,8'h00, e_capt());
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_ddone(0, 8'h2A));
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_idle());
    // C out of range (0x40): ack+err in cycle 1, no bus activity
    add(0,0, 1,0,8'h40,8'h00, 0,0,8'h00,8'h00, e_idle());
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_cdone(1, 8'h00));
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_idle());
    // D out-of-range write (0xFF)
    add(0,0, 0,0,8'h00,8'h00, 1,1,8'hFF,8'h77, e_idle());
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_ddone(1, 8'h00));
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_idle());
    // C write at the last valid address 0x3F
    add(0,0, 1,1,8'h3F,8'h99, 0,0,8'h00,8'h00, e_idle());
    add(0,0, 1,1,8'h3F,8'h99, 0,0,8'h00,8'h00, e_addr(8'h3F));
    add(0,0, 1,1,8'h3F,8'h99, 0,0,8'h00,8'h00, e_xfer(8'h99, 0));
    add(0,0, 1,1,8'h3F,8'h99, 0,0,8'h00,8'h00, e_capt());
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_cdone(0, 8'h00));
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_idle());
    // reset during XFER of a write to 0x07: abandoned, no ack
    add(0,0, 1,1,8'h07,8'h55, 0,0,8'h00,8'h00, e_idle());
    add(0,0, 1,1,8'h07,8'h55, 0,0,8'h00,8'h00, e_addr(8'h07));
    add(1,0, 1,1,8'h07,8'h55, 0,0,8'h00,8'h00, e_xfer(8'h55, 0));
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_idle());
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_idle());
    // reset during ADDR of a write to 0x08: memory must not change
    add(0,0, 1,1,8'h08,8'h66, 0,0,8'h00,8'h00, e_idle());
    add(1,0, 1,1,8'h08,8'h66, 0,0,8'h00,8'h00, e_addr(8'h08));
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_idle());
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_idle());
    // after reset a tie goes to C, then D
    add(0,0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, e_idle());
    add(0,0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, e_addr(8'h01));
    add(0,0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, e_xfer(8'h00, 1));
    add(0,0, 1,0,8'h01,8'h00, 1,0,8'h02,8'h00, e_capt());
    add(0,0, 0,0,8'h00,8'h00, 1,0,8'h02,8'h00, e_cdone(0, 8'h04));
    add(0,0, 0,0,8'h00,8'h00, 1,0,8'h02,8'h00, e_idle());
    add(0,0, 0,0,8'h00,8'h00, 1,0,8'h02,8'h00, e_addr(8'h02));
    add(0,0, 0,0,8'h00,8'h00, 1,0,8'h02,8'h00, e_xfer(8'h00, 1));
    add(0,0, 0,0,8'h00,8'h00, 1,0,8'h02,8'h00, e_capt());
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_ddone(0, 8'h07));
    add(0,0, 0,0,8'h00,8'h00, 0,0,8'h00,8'h00, e_idle());

    @(posedge clk);
    @(posedge clk);
    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; pause = tbl[i].pause;
      c_req = tbl[i].c_req; c_we = tbl[i].c_we; c_addr = tbl[i].c_addr; c_wdata = tbl[i].c_wdata;
      d_req = tbl[i].d_req; d_we = tbl[i].d_we; d_addr = tbl[i].d_addr; d_wdata = tbl[i].d_wdata;
      #1;
      chk("vec", i, outs(), tbl[i].exp);
    end

    chk("mem5", 0, 32'(mem[5]), 32'h2A);
    chk("mem63", 0, 32'(mem[63]), 32'h99);
    chk("mem8", 0, 32'(mem[8]), 32'h22);

    // Contention: both held from reset -> C, D, C, D with acks at 4, 9, 14, 19
    reset_dut();
    c_req = 1; d_req = 1; c_addr = 8'h03; d_addr = 8'h04;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      #1;
      chk("contend", cyc, {30'd0, c_ack, d_ack},
          {30'd0, (cyc == 4 || cyc == 14), (cyc == 9 || cyc == 19)});
      if (ALE && En) chk("ale_en", cyc, 32'd1, 32'd0);
      @(negedge clk);
    end

    // Pause: only D served; dropping pause lets C win at the next IDLE
    reset_dut();
    pause = 1; c_req = 1; d_req = 1; c_addr = 8'h03; d_addr = 8'h04;
    for (int cyc = 0; cyc <= 19; cyc++) begin
      pause = (cyc < 13);
      #1;
      chk("pause", cyc, {30'd0, c_ack, d_ack},
          {30'd0, (cyc == 19), (cyc == 4 || cyc == 9 || cyc == 14)});
      @(negedge clk);
    end
    clear_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
